// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//
// Purpose:
//   Sequencer between instruction issue and a shared 32-bit combinational ALU.
//   One operation is accepted per request handshake. Single-cycle operations
//   are sent to the ALU for one EXEC cycle. Multi-bit shifts are built by
//   repeatedly applying the ALU's shift-by-1 operations, one step per cycle.
//   The final result and overflow flag are then held on a response channel.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The request side is ready only in IDLE, and req_* is sampled only on that
//   edge. The response side holds resp_valid, resp_result and resp_overflow
//   stable until the transfer edge. No new request is taken on the response
//   transfer edge, so back-to-back operations always see one IDLE cycle.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready, req_op, req_a, req_b, req_shamt   request channel
//   resp_valid/resp_ready, resp_result, resp_overflow     response channel
//   busy           high in every state except IDLE
//   alu_a, alu_b, alu_op        operands/opcode driven to the ALU
//   alu_result, alu_overflow    combinational ALU outputs
//   dbg_state      current FSM state (IDLE=0, EXEC=1, SHIFT=2, DONE=3)
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [3:0]         req_op,
   input  logic [DATA_W-1:0]  req_a,
   input  logic [DATA_W-1:0]  req_b,
   input  logic [SHAMT_W-1:0] req_shamt,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [DATA_W-1:0]  resp_result,
   output logic               resp_overflow,
   output logic               busy,
   output logic [DATA_W-1:0]  alu_a,
   output logic [DATA_W-1:0]  alu_b,
   output logic [3:0]         alu_op,
   input  logic [DATA_W-1:0]  alu_result,
   input  logic               alu_overflow,
   output logic [1:0]         dbg_state
);

   // FSM encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // ALU opcodes
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_SLL = 4'b0010;
   localparam logic [3:0] OP_SRL = 4'b0011;
   localparam logic [3:0] OP_SRA = 4'b0100;
   localparam logic [3:0] OP_NEG = 4'b0101;
   localparam logic [3:0] OP_CMP = 4'b0110;
   localparam logic [3:0] OP_AND = 4'b0111;
   localparam logic [3:0] OP_OR  = 4'b1000;

   logic [1:0]         state_q, state_d;
   logic [3:0]         op_q,    op_d;
   logic [DATA_W-1:0]  acc_q,   acc_d;    // operand A, then running shift value
   logic [DATA_W-1:0]  b_q,     b_d;
   logic [SHAMT_W-1:0] cnt_q,   cnt_d;    // shift steps still to apply
   logic [DATA_W-1:0]  res_q,   res_d;
   logic               ovf_q,   ovf_d;

   logic req_is_shift;
   logic req_is_valid;

   always_comb begin
      req_is_shift = (req_op == OP_SLL) || (req_op == OP_SRL) || (req_op == OP_SRA);
      req_is_valid = (req_op <= OP_OR);
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE: begin
            // req_ready is implied by being in IDLE
            if (req_valid) begin
               op_d  = req_op;
               acc_d = req_a;
               b_d   = req_b;
               cnt_d = req_shamt;
               if (!req_is_valid) begin
                  // Unknown opcode: answer immediately without using the ALU
                  state_d = ST_DONE;
                  res_d   = '0;
                  ovf_d   = 1'b0;
               end else if (req_is_shift) begin
                  if (req_shamt == '0) begin
                     // Zero-length shift is the identity; skip the ALU
                     state_d = ST_DONE;
                     res_d   = req_a;
                     ovf_d   = 1'b0;
                  end else begin
                     state_d = ST_SHIFT;
                  end
               end else begin
                  state_d = ST_EXEC;
               end
            end
         end

         ST_EXEC: begin
            res_d   = alu_result;
            ovf_d   = alu_overflow;
            state_d = ST_DONE;
         end

         ST_SHIFT: begin
            acc_d = alu_result;
            cnt_d = cnt_q - SHAMT_W'(1);
            if (cnt_q == SHAMT_W'(1)) begin
               // Last step: the ALU flag means nothing for shifts, force it low
               res_d   = alu_result;
               ovf_d   = 1'b0;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
      end
   end

   // Output decode. The ALU sees zeros whenever it is not in use so that a
   // shared ALU is never driven with stale operands.
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = OP_ADD;
      if (state_q == ST_EXEC) begin
         alu_a  = acc_q;
         alu_b  = b_q;
         alu_op = op_q;
      end else if (state_q == ST_SHIFT) begin
         alu_a  = acc_q;
         alu_op = op_q;
      end
   end

   always_comb begin
      req_ready     = (state_q == ST_IDLE);
      busy          = (state_q != ST_IDLE);
      resp_valid    = (state_q == ST_DONE);
      resp_result   = res_q;
      resp_overflow = ovf_q;
      dbg_state     = state_q;
   end

endmodule
